// File: rtl/ccip_avmm_requestor_arbiter.sv
// Two-requester arbiter in front of the CCI-P to Avalon-MM requestor datapath.
// Round-robin between requesters, with write bursts locked to their owner
// until the last beat is accepted.
//
// Command bit layout (t_ccip_avmm_requestor_cmd, LSB first):
//   [0]        control[0]  1 = write beat, 0 = read
//   [3:1]      burst       total write beats, 0 treated as 1
//   [515:4]    write_data
//   [563:516]  addr
//
// Build option: define CCIP_AVMM_ARB_OUTPUT_REG_EN to register out_cmd,
// out_valid and out_src (1-cycle latency). Without it the output is a
// combinational pass-through (0-cycle latency).
module ccip_avmm_requestor_arbiter #(
  parameter int unsigned CMD_WIDTH = 564
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CMD_WIDTH-1:0] in0_cmd,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [CMD_WIDTH-1:0] in1_cmd,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  output logic [CMD_WIDTH-1:0] out_cmd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_src
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam int unsigned CTRL_BIT  = 0;
  localparam int unsigned BURST_LSB = 1;

  logic       state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [2:0] beats_left_q, beats_left_d;
  // A grant presented but not yet accepted is held so the arbiter never
  // switches away from a requester that is still waiting.
  logic       hold_q, hold_d;
  logic       hold_src_q, hold_src_d;

  logic                 grant_valid;
  logic                 grant_src;
  logic [CMD_WIDTH-1:0] grant_cmd;
  logic                 can_accept;
  logic                 accept;
  logic [2:0]           burst;
  logic                 multi_beat;

  // Pick the requester that owns the output this cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant_src   = owner_q;
      grant_valid = owner_q ? in1_valid : in0_valid;
    end else if (hold_q && (hold_src_q ? in1_valid : in0_valid)) begin
      grant_src   = hold_src_q;
      grant_valid = 1'b1;
    end else if (in0_valid && in1_valid) begin
      grant_src   = rr_ptr_q;
      grant_valid = 1'b1;
    end else if (in0_valid) begin
      grant_src   = 1'b0;
      grant_valid = 1'b1;
    end else if (in1_valid) begin
      grant_src   = 1'b1;
      grant_valid = 1'b1;
    end
  end

  assign grant_cmd  = grant_src ? in1_cmd : in0_cmd;
  assign accept     = grant_valid && can_accept;
  assign burst      = grant_cmd[BURST_LSB +: 3];
  // Burst 0 and 1 are both single-beat; reads ignore the burst field.
  assign multi_beat = grant_cmd[CTRL_BIT] && (burst > 3'd1);

  // Next-state logic for the lock FSM, beat counter and round-robin pointer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    hold_d       = grant_valid && !accept;
    hold_src_d   = grant_src;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (multi_beat) begin
          state_d      = ST_LOCKED;
          beats_left_d = burst - 3'd1;
          owner_d      = grant_src;
        end else begin
          rr_ptr_d = ~grant_src;
        end
      end else begin
        if (beats_left_q <= 3'd1) begin
          state_d      = ST_IDLE;
          beats_left_d = 3'd0;
          rr_ptr_d     = ~owner_q;
        end else begin
          beats_left_d = beats_left_q - 3'd1;
        end
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      beats_left_q <= 3'd0;
      hold_q       <= 1'b0;
      hold_src_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      hold_q       <= hold_d;
      hold_src_q   <= hold_src_d;
    end
  end

`ifdef CCIP_AVMM_ARB_OUTPUT_REG_EN
  logic                 out_valid_q;
  logic                 out_src_q;
  logic [CMD_WIDTH-1:0] out_cmd_q;

  // Skid-free register: accept a new beat whenever the slot is empty or draining.
  assign can_accept = !out_valid_q || out_ready;

  // Output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      out_cmd_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_src_q   <= grant_src;
      out_cmd_q   <= grant_cmd;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign out_cmd   = out_cmd_q;
`else
  assign can_accept = out_ready;
  // Reset is asynchronous, so the combinational outputs are forced as well.
  assign out_valid  = grant_valid && !reset;
  assign out_src    = grant_src && !reset;
  assign out_cmd    = grant_cmd;
`endif

  assign in0_ready = grant_valid && !grant_src && can_accept && !reset;
  assign in1_ready = grant_valid && grant_src && can_accept && !reset;

endmodule

// File: doc/ccip_avmm_requestor_arbiter.md
CCIP_AVMM_REQUESTOR_ARBITER -- requirements
Module: ccip_avmm_requestor_arbiter

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 564 (ccip_avmm_pkg::CCIP_AVMM_REQUESTOR_CMD_WIDTH), width of one packed t_ccip_avmm_requestor_cmd.
REQ-002 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in0_cmd  input  CMD_WIDTH  requester 0 command (addr, write_data, burst, control).
REQ-005 SHALL have port in0_valid  input  1  requester 0 command present.
REQ-006 SHALL have port in0_ready  output  1  requester 0 command accepted this cycle when in0_valid is also high.
REQ-007 SHALL have ports in1_cmd, in1_valid and in1_ready, identical to REQ-004..006, for requester 1.
REQ-008 SHALL have port out_cmd  output  CMD_WIDTH  granted command toward the requestor datapath.
REQ-009 SHALL have port out_valid  output  1  out_cmd valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_cmd this cycle.
REQ-011 SHALL have port out_src  output  1  index of the requester that owns out_cmd.

Function
REQ-012 SHALL decode control[0]=1 as a write beat and control[0]=0 as a read; burst field = total write beats, 1..7, with 0 treated as 1; the burst field is ignored for reads (one command).
REQ-013 SHALL implement FSM states IDLE and LOCKED.
REQ-014 In IDLE, SHALL grant the requester with valid asserted; if both are valid, SHALL grant the one selected by the round-robin pointer rr_ptr.
REQ-015 On acceptance of a write beat with burst>1 in IDLE, SHALL load beats_left=burst-1, record the owner, and go to LOCKED.
REQ-016 In LOCKED, SHALL grant only the owner, ignore the other requester, decrement beats_left per accepted beat, and return to IDLE when the beat with beats_left=1 is accepted; the burst field of non-first beats SHALL be ignored.
REQ-017 SHALL set rr_ptr to the other requester only when a read, a single-beat write, or the final beat of a write burst is accepted; rr_ptr SHALL NOT change mid-burst.
REQ-018 SHALL assert at most one of in0_ready and in1_ready per cycle; a non-granted requester's ready SHALL be 0.
REQ-019 SHALL never drop, duplicate or reorder beats within a requester; out_cmd SHALL equal the accepted input bits unmodified.
REQ-020 Requesters SHALL hold cmd and valid stable until accepted; the arbiter SHALL NOT re-arbitrate away from a requester that is presenting valid but not yet accepted.
REQ-021 In LOCKED with owner valid low, SHALL hold the lock with out_valid=0 (no timeout).

Reset
REQ-022 On reset assertion, SHALL asynchronously force state=IDLE, rr_ptr=0, beats_left=0, out_valid=0, out_src=0, in0_ready=0 and in1_ready=0; out_cmd SHALL be 0 when the output register is present.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; the first command accepted after reset SHALL be arbitrated from IDLE.

Configuration
REQ-024 Macro CCIP_AVMM_ARB_OUTPUT_REG_EN SHALL select the output stage.
REQ-025 Without the macro, SHALL be combinational pass-through: out_valid = granted valid, inX_ready = grant_X & out_ready, 0-cycle latency.
REQ-026 With the macro, SHALL register out_cmd, out_valid and out_src, giving 1-cycle latency; inX_ready = grant_X & (!out_valid | out_ready), sustaining 1 beat/cycle; FSM and rr_ptr SHALL advance on input acceptance.

Verification
REQ-027 Both requesters issue continuous reads after reset -> out_src alternates 0,1,0,1; each read is output exactly once.
REQ-028 Requester 0 writes burst=4 while requester 1 holds a read valid -> four consecutive beats with out_src=0, then requester 1's read; rr_ptr=0 after the read.
REQ-029 LOCKED owner drops valid for 3 cycles mid-burst with requester 1 valid -> out_valid=0 for those 3 cycles, in1_ready=0, burst resumes.
REQ-030 out_ready held 0 for 5 cycles with both valid -> out_cmd and out_src stable, no beat lost; the same beat is accepted when out_ready rises.
REQ-031 Reset pulsed after beat 2 of a burst=7 write -> all outputs at reset values; the next requester-1 read is granted immediately from IDLE.
REQ-032 Write with burst=0 -> treated as a single beat; FSM stays in IDLE and rr_ptr toggles.
